// File: rtl/im_load_ctrl_f.sv
// im_load_ctrl_f -- instruction store and boot sequencer for the F stage.
//
// The store goes through three phases after reset:
//   CLEAR : one word is zero-filled per cycle, DEPTH cycles in total.
//   LOAD  : a boot loader streams words in over a valid/ready port. The
//           pipeline stays frozen until a transfer marked ld_last.
//   RUN   : the F stage fetches combinationally. Misaligned or
//           out-of-range fetches return a nop and raise f_adel.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   ld_valid/ready   loader handshake (ready only in LOAD)
//   ld_addr/ld_data  loader byte address and data word
//   ld_last          final loader word; moves the block to RUN
//   ld_err           sticky: a loader write was rejected
//   ld_cnt           accepted loader writes, saturating
//   handler_present  sticky: a word was written at HANDLER_BASE
//   f_addr           fetch byte address (PC)
//   f_instr          fetched instruction (0 unless a legal RUN fetch)
//   f_stall          freeze PC and IF/ID (high outside RUN)
//   f_adel           fetch address error (RUN only)
//   phase            0=CLEAR, 1=LOAD, 2=RUN
module im_load_ctrl_f #(
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter logic [31:0] TEXT_BASE    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_4180
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_err,
  output logic [DEPTH_LOG2:0]   ld_cnt,
  output logic                  handler_present,
  input  logic [31:0]           f_addr,
  output logic [31:0]           f_instr,
  output logic                  f_stall,
  output logic                  f_adel,
  output logic [1:0]            phase
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } phase_t;

  phase_t                  phase_q;
  logic [DEPTH_LOG2-1:0]   clr_idx;
  logic [31:0]             mem [DEPTH];

  // Address decode. Subtraction wraps, so addresses below TEXT_BASE
  // become large offsets and fail the range test.
  logic [31:0]             ld_off;
  logic                    ld_ok;
  logic [DEPTH_LOG2-1:0]   ld_idx;
  logic [31:0]             f_off;
  logic                    f_ok;
  logic [DEPTH_LOG2-1:0]   f_idx;
  logic                    ld_fire;

  assign ld_off  = ld_addr - TEXT_BASE;
  assign ld_ok   = (ld_addr[1:0] == 2'b00) && (ld_off < SPAN);
  assign ld_idx  = ld_off[DEPTH_LOG2+1:2];
  assign f_off   = f_addr - TEXT_BASE;
  assign f_ok    = (f_addr[1:0] == 2'b00) && (f_off < SPAN);
  assign f_idx   = f_off[DEPTH_LOG2+1:2];

  assign phase    = phase_q;
  assign ld_ready = (phase_q == LOAD);
  assign f_stall  = (phase_q != RUN);
  assign ld_fire  = ld_valid && ld_ready;

  // Single write port shared by the zero-fill and the loader; the two
  // phases are exclusive, so a mux on phase is enough.
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_wa;
  logic [31:0]             mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_idx;
    mem_wd = '0;
    if (!reset) begin
      case (phase_q)
        CLEAR: mem_we = 1'b1;
        LOAD: begin
          if (ld_fire && ld_ok) begin
            mem_we = 1'b1;
            mem_wa = ld_idx;
            mem_wd = ld_data;
          end
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Phase sequencer, loader bookkeeping and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q         <= CLEAR;
      clr_idx         <= '0;
      ld_err          <= 1'b0;
      ld_cnt          <= '0;
      handler_present <= 1'b0;
    end else begin
      case (phase_q)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) phase_q <= LOAD;
        end
        LOAD: begin
          if (ld_fire) begin
            if (ld_ok) begin
              if (ld_cnt != '1) ld_cnt <= ld_cnt + 1'b1;
              if (ld_addr == HANDLER_BASE) handler_present <= 1'b1;
            end else begin
              ld_err <= 1'b1;
            end
            // A rejected final word still ends the load.
            if (ld_last) phase_q <= RUN;
          end
        end
        RUN: phase_q <= RUN;
        default: begin
          // Encoding 3 is unreachable in normal operation; restart cleanly.
          phase_q <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Zero-latency fetch, like a register-file read.
  always_comb begin
    f_instr = '0;
    f_adel  = 1'b0;
    if (phase_q == RUN) begin
      if (f_ok) f_instr = mem[f_idx];
      else      f_adel  = 1'b1;
    end
  end

endmodule

// File: tb/tb_im_load_ctrl_f.sv
module tb_im_load_ctrl_f;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_err;
  logic [4:0]  ld_cnt;
  logic        handler_present;
  logic [31:0] f_addr;
  logic [31:0] f_instr;
  logic        f_stall;
  logic        f_adel;
  logic [1:0]  phase;

  im_load_ctrl_f #(
    .DEPTH_LOG2  (4),
    .TEXT_BASE   (32'h0000_3000),
    .HANDLER_BASE(32'h0000_3020)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .ld_err         (ld_err),
    .ld_cnt         (ld_cnt),
    .handler_present(handler_present),
    .f_addr         (f_addr),
    .f_instr        (f_instr),
    .f_stall        (f_stall),
    .f_adel         (f_adel),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: store contents and status as plain values.
  logic [31:0] m_mem [16];
  int          m_cnt;
  bit          m_err;
  bit          m_hp;
  int          m_phase;   // 0 clear, 1 load, 2 run

  function automatic bit m_legal(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h0000_3000;
    return (a[1:0] == 2'b00) && (off < 32'd64);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_cnt = 0; m_err = 0; m_hp = 0; m_phase = 0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
    repeat (cycles) step();
    model_reset();
    n_checks++;
    if (phase !== 2'd0 || ld_cnt !== 5'd0 || ld_err !== 1'b0 || handler_present !== 1'b0
        || ld_ready !== 1'b0 || f_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d cnt=%0d err=%b hp=%b rdy=%b stall=%b, need 0/0/0/0/0/1",
               phase, ld_cnt, ld_err, handler_present, ld_ready, f_stall);
    end
    reset = 1'b0;
  endtask

  // Counts CLEAR cycles after reset release; bounded.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (phase == 2'd0 && n < 40) begin
      n_checks++;
      if (f_instr !== 32'h0 || f_adel !== 1'b0 || ld_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_clear_outs: instr=%h adel=%b rdy=%b, need 0/0/0", tag, f_instr, f_adel, ld_ready);
      end
      step();
      n++;
    end
    m_phase = 1;
    n_checks++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL %s_clear_len: got %0d cycles, need 16", tag, n);
    end
    n_checks++;
    if (phase !== 2'd1 || ld_ready !== 1'b1 || f_stall !== 1'b1 || f_instr !== 32'h0 || f_adel !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_load_entry: phase=%0d rdy=%b stall=%b instr=%h adel=%b, need 1/1/1/0/0",
               tag, phase, ld_ready, f_stall, f_instr, f_adel);
    end
  endtask

  // One loader cycle; inputs stay driven afterwards so calls can go back to back.
  task automatic xfer(input bit v, input logic [31:0] a, input logic [31:0] d, input bit last,
                      input string tag);
    ld_valid = v; ld_addr = a; ld_data = d; ld_last = last;
    n_checks++;
    if (ld_ready !== (m_phase == 1)) begin
      n_fail++;
      $display("FAIL %s_ready: got %b, need %b", tag, ld_ready, (m_phase == 1));
    end
    step();
    if (v && m_phase == 1) begin
      if (m_legal(a)) begin
        m_mem[(a - 32'h3000) >> 2] = d;
        if (m_cnt < 31) m_cnt++;
        if (a == 32'h0000_3020) m_hp = 1;
      end else begin
        m_err = 1;
      end
      if (last) m_phase = 2;
    end
    n_checks++;
    if (ld_cnt !== 5'(m_cnt) || ld_err !== m_err || handler_present !== m_hp
        || phase !== 2'(m_phase)) begin
      n_fail++;
      $display("FAIL %s_status: cnt=%0d err=%b hp=%b phase=%0d, need %0d/%b/%b/%0d",
               tag, ld_cnt, ld_err, handler_present, phase, m_cnt, m_err, m_hp, m_phase);
    end
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input string tag);
    logic [31:0] ei;
    bit          ea;
    f_addr = a;
    #1;
    ei = '0; ea = 0;
    if (m_phase == 2) begin
      if (m_legal(a)) ei = m_mem[(a - 32'h3000) >> 2];
      else            ea = 1;
    end
    n_checks++;
    if (f_instr !== ei || f_adel !== ea || f_stall !== (m_phase != 2)) begin
      n_fail++;
      $display("FAIL %s_fetch@%h: instr=%h adel=%b stall=%b, need %h/%b/%b",
               tag, a, f_instr, f_adel, f_stall, ei, ea, (m_phase != 2));
    end
  endtask

  task automatic test_reset();
    apply_reset(2);
    wait_clear("reset");
  endtask

  task automatic test_basic_load();
    xfer(1, 32'h3000, 32'h2401_0001, 0, "basic0");
    xfer(1, 32'h3004, 32'h2402_0002, 0, "basic1");
    xfer(1, 32'h3008, 32'h0022_1820, 1, "basic2");
    idle();
    fetch(32'h3004, "basic");
    n_checks++;
    if (f_instr !== 32'h2402_0002 || ld_cnt !== 5'd3 || f_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: instr=%h cnt=%0d stall=%b, need 24020002/3/0", f_instr, ld_cnt, f_stall);
    end
    for (int i = 0; i < 16; i++) fetch(32'h3000 + 32'(i * 4), "basic_all");
  endtask

  task automatic test_reject();
    apply_reset(1);
    wait_clear("rej");
    xfer(1, 32'h3002, 32'h1111_1111, 0, "rej_mis");
    xfer(1, 32'h3040, 32'h2222_2222, 0, "rej_end");
    xfer(1, 32'h2FFC, 32'h3333_3333, 0, "rej_below");
    n_checks++;
    if (ld_err !== 1'b1 || ld_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL rej_flags: err=%b cnt=%0d, need 1/0", ld_err, ld_cnt);
    end
    xfer(1, 32'h303C, 32'hDEAD_BEEF, 1, "rej_top");
    idle();
    fetch(32'h303C, "rej");
  endtask

  task automatic test_bad_fetch();
    fetch(32'h3001, "bad");
    fetch(32'h3040, "bad");
    fetch(32'h0000_0000, "bad");
    fetch(32'h2FFC, "bad");
    fetch(32'h3000, "bad");
    repeat (20) fetch(($urandom_range(0, 1) != 0) ? (32'h2FF0 + $urandom_range(0, 96)) : $urandom, "badrnd");
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] addrs [4];
    apply_reset(1);
    wait_clear("mid");
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'h3000 + 32'(i * 4);
      xfer(1, addrs[i], $urandom | 32'h1, 0, "mid_w");
    end
    xfer(1, 32'h3006, 32'h5, 0, "mid_bad");
    // Loader stays active while reset is applied.
    ld_valid = 1'b1; ld_addr = 32'h3010; ld_data = 32'hFFFF_FFFF;
    reset = 1'b1;
    step();
    model_reset();
    reset = 1'b0;
    ld_valid = 1'b0;
    n_checks++;
    if (ld_cnt !== 5'd0 || ld_err !== 1'b0 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: cnt=%0d err=%b phase=%0d, need 0/0/0", ld_cnt, ld_err, phase);
    end
    wait_clear("mid2");
    xfer(1, 32'h3030, 32'h0000_0042, 1, "mid_last");
    idle();
    for (int i = 0; i < 4; i++) fetch(addrs[i], "mid_zero");
    fetch(32'h3010, "mid_zero");
    fetch(32'h3030, "mid_last");
  endtask

  task automatic test_handler_and_run_ignore();
    apply_reset(1);
    wait_clear("hnd");
    xfer(1, 32'h3024, 32'hAAAA_0001, 0, "hnd_near");
    xfer(1, 32'h3020, 32'h4000_0000, 0, "hnd_hit");
    xfer(1, 32'h3000, 32'h0101_0101, 1, "hnd_last");
    for (int i = 0; i < 6; i++)
      xfer(1, 32'h3000 + 32'(i * 4), $urandom, (i % 2) == 1, "run_ign");
    idle();
    n_checks++;
    if (ld_cnt !== 5'd3 || handler_present !== 1'b1) begin
      n_fail++;
      $display("FAIL run_ignore: cnt=%0d hp=%b, need 3/1", ld_cnt, handler_present);
    end
    for (int i = 0; i < 16; i++) fetch(32'h3000 + 32'(i * 4), "run_ign");
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          v;
    apply_reset(1);
    wait_clear("rnd");
    for (int i = 0; i < 70; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       a = 32'h2FF0 + $urandom_range(0, 96);
        1:       a = $urandom;
        default: a = 32'h3000 + 32'($urandom_range(0, 15) * 4);
      endcase
      // ld_last is only honoured with ld_valid; toggle it freely when idle.
      xfer(v, a, $urandom, v ? 1'b0 : 1'($urandom_range(0, 1)), "rnd");
    end
    xfer(1, 32'h3000 + 32'($urandom_range(0, 15) * 4), $urandom, 1, "rnd_last");
    idle();
    for (int i = 0; i < 16; i++) fetch(32'h3000 + 32'(i * 4), "rnd");
    repeat (10) fetch(32'h3000 + $urandom_range(0, 80), "rnd_any");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    f_addr = 32'h3000;
    model_reset();
    test_reset();
    test_basic_load();
    test_bad_fetch();
    test_reject();
    test_bad_fetch();
    test_reset_mid_load();
    test_handler_and_run_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
